cges_stream_monitor: RTL and testbench

Downstream consumer of the target IP's free-running `cges` count. It samples the count every clock and checks that it follows the required increment-and-wrap sequence. It flags wraps and sequence errors, and pushes decimated samples into a small FIFO drained through a valid/ready interface toward the host-side capture logic.

---
 rtl/cges_stream_monitor.sv | 150 +++++++++++++++
 tb/tb_cges_stream_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cges_stream_monitor.sv
// cges_stream_monitor: checks the free-running cges count for increment-and-wrap order, flags wraps and
// errors, and queues decimated samples in a valid/ready FIFO. Define CGES_MON_ERRCNT_EN to keep err_count.
module cges_stream_monitor #(
   parameter int CGES     = 13,
   parameter int WRAP_MAX = (1 << (CGES - 2)) - 1,
   parameter int DECIM    = 4,
   parameter int DEPTH    = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [CGES-2:0] cges_in,
   input  logic            sample_en,
   output logic [CGES-2:0] m_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            wrap_pulse,
   output logic            err_pulse,
   output logic [15:0]     err_count,
   output logic            overflow
);

   localparam int W  = CGES - 1;
   localparam int AW = $clog2(DEPTH);

   localparam logic [W-1:0] WMAX     = W'(WRAP_MAX);
   localparam logic [7:0]   DEC_LAST = 8'(DECIM - 1);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  PTR_ONE  = (AW+1)'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sample_en) state_nxt = S_PRIME;
         S_PRIME: state_nxt = sample_en ? S_RUN : S_IDLE;
         S_RUN:   state_nxt = sample_en ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Stage 1: register the input and tag it with what the FSM intends to do with it.
   logic [W-1:0] in_q;
   logic         s1_prime;
   logic         s1_run;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_q     <= '0;
         s1_prime <= 1'b0;
         s1_run   <= 1'b0;
      end else begin
         in_q     <= cges_in;
         s1_prime <= (state == S_PRIME) && sample_en;
         s1_run   <= (state == S_RUN) && sample_en;
      end
   end

   // Stage 2: sequence check against the previous value, then resynchronise to the new one.
   logic [W-1:0] prev;
   logic [W-1:0] exp_val;
   logic         sample_good;
   logic [7:0]   dcnt;
   logic         push_q;
   logic [W-1:0] push_data;

   assign exp_val     = (prev == WMAX) ? '0 : prev + W'(1);
   assign sample_good = (in_q == exp_val) && (in_q <= WMAX);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev       <= '0;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         dcnt       <= '0;
         push_q     <= 1'b0;
         push_data  <= '0;
      end else begin
         wrap_pulse <= s1_run && sample_good && (prev == WMAX);
         err_pulse  <= s1_run && !sample_good;
         push_q     <= s1_run && (dcnt == 8'd0);
         push_data  <= in_q;
         if (s1_prime || s1_run) prev <= in_q;
         if (s1_run)
            dcnt <= (dcnt == DEC_LAST) ? 8'd0 : dcnt + 8'd1;
         else if (state == S_IDLE)
            dcnt <= 8'd0;
      end
   end

`ifdef CGES_MON_ERRCNT_EN
   logic [15:0] err_count_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         err_count_q <= 16'd0;
      else if (s1_run && !sample_good && (err_count_q != 16'hFFFF))
         err_count_q <= err_count_q + 16'd1;
   end

   assign err_count = err_count_q;
`else
   assign err_count = 16'd0;
`endif

   // Output handshake: a beat transfers on a rising edge where m_valid && m_ready; until then
   // m_valid stays high and m_data holds the same head entry.
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  occ;
   logic         full;
   logic         pop;
   logic         push_ok;

   assign occ     = wr_ptr - rd_ptr;
   assign full    = (occ == FULL_CNT);
   assign m_valid = (wr_ptr != rd_ptr);
   assign pop     = m_valid && m_ready;
   // A pop frees the slot the same edge, so a push against a full FIFO still lands.
   assign push_ok = push_q && (!full || pop);
   assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)           wr_ptr   <= wr_ptr + PTR_ONE;
         if (pop)               rd_ptr   <= rd_ptr + PTR_ONE;
         if (push_q && !push_ok) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cges_stream_monitor.sv
// Bench for cges_stream_monitor: two instances (DECIM=4 and DECIM=1) share one stimulus stream and are
// compared against a segment-level reference model through scheduled-event queues.
module tb_cges_stream_monitor;

   localparam int W = 12;
   localparam logic [W-1:0] WMAX = 12'd2047;
   localparam int DEPTH = 8;
   localparam int DECIM0 = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           sample_en;
   logic [W-1:0]   cges_in;
   logic [1:0]     m_ready;
   logic [W-1:0]   m_data [2];
   logic [1:0]     m_valid;
   logic [1:0]     wrap_pulse;
   logic [1:0]     err_pulse;
   logic [15:0]    err_count [2];
   logic [1:0]     overflow;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cges_stream_monitor #(.CGES(13), .DECIM(DECIM0), .DEPTH(DEPTH)) u0 (
      .clk(clk), .reset_n(reset_n), .cges_in(cges_in), .sample_en(sample_en),
      .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
      .wrap_pulse(wrap_pulse[0]), .err_pulse(err_pulse[0]), .err_count(err_count[0]),
      .overflow(overflow[0])
   );

   cges_stream_monitor #(.CGES(13), .DECIM(1), .DEPTH(DEPTH)) u1 (
      .clk(clk), .reset_n(reset_n), .cges_in(cges_in), .sample_en(sample_en),
      .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
      .wrap_pulse(wrap_pulse[1]), .err_pulse(err_pulse[1]), .err_count(err_count[1]),
      .overflow(overflow[1])
   );

   // Scoreboard: cycle stamps of expected pulses, and expected FIFO writes (edge, data, unit mask).
   int           wrap_q[$];
   int           err_q[$];
   int           wr_cyc[$];
   logic [W-1:0] wr_dat[$];
   logic [1:0]   wr_msk[$];

   logic [W-1:0] mfifo [2][DEPTH];
   int           mcnt [2];
   bit           movf [2];
   int           merr;
   bit           rst_seen;
   bit           end_chk;
   bit           end_done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] seg[$];

   function automatic logic [W-1:0] nxt(input logic [W-1:0] p);
      return (p == WMAX) ? '0 : p + 12'd1;
   endfunction

   task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s unit%0d cycle %0d: got %0h expected %0h", name, u, cyc, act, exp);
      end
   endtask

   // Monitor: compare outputs of the current cycle, then advance the model across the next edge.
   initial begin
      mcnt[0] = 0; mcnt[1] = 0; movf[0] = 0; movf[1] = 0;
      merr = 0; rst_seen = 0; end_done = 0;
   end

   always @(negedge clk) begin
      bit ew, ee, p;
      logic [1:0] wm;
      logic [W-1:0] wd;
      ew = (wrap_q.size() > 0) && (wrap_q[0] == cyc);
      if (ew) void'(wrap_q.pop_front());
      ee = (err_q.size() > 0) && (err_q[0] == cyc);
      if (ee) void'(err_q.pop_front());
      if (ee && merr < 65535) merr++;
      for (int u = 0; u < 2; u++) begin
         chk("wrap_pulse", u, 32'(wrap_pulse[u]), 32'(ew));
         chk("err_pulse", u, 32'(err_pulse[u]), 32'(ee));
`ifdef CGES_MON_ERRCNT_EN
         chk("err_count", u, 32'(err_count[u]), 32'(merr));
`else
         chk("err_count", u, 32'(err_count[u]), 32'd0);
`endif
         chk("m_valid", u, 32'(m_valid[u]), 32'(mcnt[u] > 0));
         if (mcnt[u] > 0) chk("m_data", u, 32'(m_data[u]), 32'(mfifo[u][0]));
         if (rst_seen) chk("m_data_reset", u, 32'(m_data[u]), 32'd0);
         chk("overflow", u, 32'(overflow[u]), 32'(movf[u]));
      end
      if (end_chk && !end_done) begin
         end_done = 1;
         chk("pending_events", 0, 32'(wrap_q.size() + err_q.size() + wr_cyc.size()), 32'd0);
         for (int u = 0; u < 2; u++) chk("fifo_left", u, 32'(mcnt[u]), 32'd0);
      end
      if (!reset_n) begin
         wrap_q.delete(); err_q.delete(); wr_cyc.delete(); wr_dat.delete(); wr_msk.delete();
         mcnt[0] = 0; mcnt[1] = 0; movf[0] = 0; movf[1] = 0; merr = 0;
         rst_seen = 1;
      end else begin
         rst_seen = 0;
         wm = 2'b00;
         wd = '0;
         if (wr_cyc.size() > 0 && wr_cyc[0] == cyc + 1) begin
            void'(wr_cyc.pop_front());
            wm = wr_msk.pop_front();
            wd = wr_dat.pop_front();
         end
         for (int u = 0; u < 2; u++) begin
            p = (mcnt[u] > 0) && m_ready[u];
            if (p) begin
               for (int j = 0; j < DEPTH - 1; j++) mfifo[u][j] = mfifo[u][j+1];
               mcnt[u]--;
            end
            if (wm[u]) begin
               if (mcnt[u] < DEPTH) begin
                  mfifo[u][mcnt[u]] = wd;
                  mcnt[u]++;
               end else begin
                  movf[u] = 1;
               end
            end
         end
      end
   end

   // Segment: seg[0] is seen in IDLE, seg[1] primes, seg[2..] are checked against their predecessor.
   task automatic build_count(input logic [W-1:0] start, input int n);
      logic [W-1:0] v;
      seg.delete();
      seg.push_back(W'($urandom_range(0, 4095)));
      v = start;
      for (int i = 0; i < n; i++) begin
         seg.push_back(v);
         v = nxt(v);
      end
   endtask

   task automatic run_seg(input int r1_idx, input bit r1_base, input bit r_rand, input int abort_at);
      int k;
      logic [W-1:0] pv, v;
      logic [1:0] msk;
      for (int i = 0; i < seg.size(); i++) begin
         @(posedge clk); #1;
         if (i == abort_at) begin
            reset_n = 1'b0;
            sample_en = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            return;
         end
         k = cyc;
         sample_en = 1'b1;
         cges_in = seg[i];
         m_ready[0] = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         m_ready[1] = (i == r1_idx) ? 1'b1 : (r_rand ? 1'($urandom_range(0, 1)) : r1_base);
         if (i >= 2) begin
            pv = seg[i-1];
            v = seg[i];
            if ((v > WMAX) || (v != nxt(pv))) err_q.push_back(k + 2);
            else if (pv == WMAX) wrap_q.push_back(k + 2);
            msk = {1'b1, (((i - 2) % DECIM0) == 0)};
            wr_cyc.push_back(k + 3);
            wr_dat.push_back(v);
            wr_msk.push_back(msk);
         end
      end
      @(posedge clk); #1;
      sample_en = 1'b0;
   endtask

   task automatic idle(input int n, input logic [1:0] rdy);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         sample_en = 1'b0;
         m_ready = rdy;
         cges_in = W'($urandom_range(0, 4095));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      sample_en = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] st;
      reset_n = 1'b0;
      sample_en = 1'b0;
      cges_in = '0;
      m_ready = 2'b11;
      end_chk = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(2, 2'b11);

      // Clean full-range count with one wrap.
      build_count(12'd0, 2050);
      run_seg(-1, 1'b1, 1'b0, -1);
      idle(4, 2'b11);

      // 100 replaces 51, then 101.. resumes cleanly.
      build_count(12'd40, 11);
      for (int v = 100; v <= 103; v++) seg.push_back(W'(v));
      run_seg(-1, 1'b1, 1'b0, -1);
      idle(4, 2'b11);

      // Legal wrap, then an out-of-range value.
      build_count(12'd2040, 12);
      seg.push_back(12'd3000);
      for (int v = 5; v <= 7; v++) seg.push_back(W'(v));
      run_seg(-1, 1'b1, 1'b0, -1);
      idle(6, 2'b11);

      // Unit1 stalled for 12 samples: 8 kept, overflow set, then drained in order.
      build_count(W'($urandom_range(0, 2047)), 13);
      run_seg(-1, 1'b0, 1'b0, -1);
      idle(6, 2'b01);
      idle(20, 2'b11);

      // Fresh start: fill unit1 to 8, then one edge with push and pop together while full.
      do_reset();
      build_count(W'($urandom_range(0, 2047)), 12);
      run_seg(12, 1'b0, 1'b0, -1);
      idle(6, 2'b01);
      idle(20, 2'b11);

      // Randomised segments with injected glitches and random back-pressure.
      for (int s = 0; s < 8; s++) begin
         st = ($urandom_range(0, 2) == 0) ? W'(2047 - $urandom_range(0, 30)) : W'($urandom_range(0, 2047));
         build_count(st, $urandom_range(20, 120));
         for (int i = 2; i < seg.size(); i++)
            if ($urandom_range(0, 15) == 0) seg[i] = W'($urandom_range(0, 4095));
         run_seg(-1, 1'b1, 1'b1, -1);
         idle($urandom_range(1, 3), 2'($urandom_range(0, 3)));
      end

      // Reset mid-stream, then a clean re-prime.
      build_count(W'($urandom_range(0, 2047)), 60);
      run_seg(-1, 1'b1, 1'b1, 30);
      build_count(W'($urandom_range(0, 2047)), 25);
      run_seg(-1, 1'b1, 1'b1, -1);

      idle(40, 2'b11);
      @(posedge clk); #1;
      end_chk = 1;
      @(posedge clk); #1;
      end_chk = 0;
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
